branch_predictor: RTL



---
 rtl/branch_predictor_if.sv | 43 ++++
 rtl/branch_predictor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// The pipeline side is the master: it presents the fetch PC and the resolved
// control-flow outcome, and receives the prediction, the mispredict flag and
// the statistics counters.
interface branch_predictor_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    // Fetch-side lookup
    logic [XLEN-1:0]  if_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_next_pc;

    // Resolve-side update
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_next_pc;
    logic             mispredict;

    // Maintenance and statistics
    logic             bp_clear;
    logic [CNT_W-1:0] cnt_updates;
    logic [CNT_W-1:0] cnt_mispredicts;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_next_pc, bp_clear,
        input  pred_hit, pred_taken, pred_next_pc, mispredict,
               cnt_updates, cnt_mispredicts
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_next_pc, bp_clear,
        output pred_hit, pred_taken, pred_next_pc, mispredict,
               cnt_updates, cnt_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Lookup is combinational from the fetch PC; resolved branches/jumps write
// back one cycle later with no bypass to a same-cycle lookup.
module branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 12,
    parameter int CNT_W   = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    // Valid and counter state is reset; tags and targets are plain memories
    // because a cleared valid bit makes their contents irrelevant.
    logic [ENTRIES-1:0]       valid_vec;
    logic [ENTRIES-1:0][1:0]  ctr_vec;
    logic [TAG_W-1:0]         tag_mem    [ENTRIES];
    logic [XLEN-1:0]          target_mem [ENTRIES];

    logic [CNT_W-1:0]         cnt_updates_reg;
    logic [CNT_W-1:0]         cnt_mispredicts_reg;

    // Lookup fields
    logic [IDX_W-1:0]         l_idx;
    logic [TAG_W-1:0]         l_tag;
    logic                     l_hit;
    logic                     l_taken;

    // Update fields
    logic [IDX_W-1:0]         u_idx;
    logic [TAG_W-1:0]         u_tag;
    logic                     u_hit;
    logic                     u_eff_taken;
    logic                     u_entry_we;
    logic                     u_target_we;
    logic [1:0]               u_ctr_next;
    logic                     misp;

    // Bits outside the index/tag fields take no part in prediction.
    logic                     unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc, bp.upd_pc};

    // ---------------- Lookup (combinational) ----------------
    assign l_idx   = bp.if_pc[IDX_W+1:2];
    assign l_tag   = bp.if_pc[IDX_W+2 +: TAG_W];
    assign l_hit   = valid_vec[l_idx] && (tag_mem[l_idx] == l_tag);
    assign l_taken = l_hit && ctr_vec[l_idx][1];

    assign bp.pred_hit     = l_hit;
    assign bp.pred_taken   = l_taken;
    assign bp.pred_next_pc = l_taken ? target_mem[l_idx] : (bp.if_pc + XLEN'(4));

    // ---------------- Update decode ----------------
    assign u_idx       = bp.upd_pc[IDX_W+1:2];
    assign u_tag       = bp.upd_pc[IDX_W+2 +: TAG_W];
    assign u_hit       = valid_vec[u_idx] && (tag_mem[u_idx] == u_tag);
    // Jumps always count as taken regardless of upd_taken.
    assign u_eff_taken = bp.upd_is_jump || bp.upd_taken;

    // A not-taken miss leaves the BTB alone; clear suppresses any write.
    assign u_entry_we  = bp.upd_valid && !bp.bp_clear && (u_hit || u_eff_taken);
    assign u_target_we = bp.upd_valid && !bp.bp_clear && u_eff_taken;

    assign misp = bp.upd_valid &&
                  ((u_eff_taken != bp.upd_pred_taken) ||
                   (u_eff_taken && (bp.upd_target != bp.upd_pred_next_pc)));
    assign bp.mispredict = misp;

    // Next direction counter for the entry being updated.
    always_comb begin
        u_ctr_next = 2'b10;
        if (u_hit) begin
            if (bp.upd_is_jump) begin
                u_ctr_next = 2'b11;
            end else if (bp.upd_taken) begin
                u_ctr_next = (ctr_vec[u_idx] == 2'b11) ? 2'b11 : ctr_vec[u_idx] + 2'b01;
            end else begin
                u_ctr_next = (ctr_vec[u_idx] == 2'b00) ? 2'b00 : ctr_vec[u_idx] - 2'b01;
            end
        end else begin
            u_ctr_next = bp.upd_is_jump ? 2'b11 : 2'b10;
        end
    end

    // ---------------- Per-entry valid/counter state ----------------
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic       valid_reg;
        logic [1:0] ctr_reg;

        // Clear wins over a same-cycle update; otherwise write the selected entry.
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                valid_reg <= 1'b0;
                ctr_reg   <= 2'b01;
            end else if (bp.bp_clear) begin
                valid_reg <= 1'b0;
            end else if (u_entry_we && (u_idx == IDX_W'(gi))) begin
                valid_reg <= 1'b1;
                ctr_reg   <= u_ctr_next;
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign ctr_vec[gi]   = ctr_reg;
    end

    // Tag and target storage; an allocation rewrites the tag, a taken hit
    // rewrites it with the same value.
    always_ff @(posedge sys_clk) begin
        if (u_target_we) begin
            tag_mem[u_idx]    <= u_tag;
            target_mem[u_idx] <= bp.upd_target;
        end
    end

    // ---------------- Statistics ----------------
    // Wrapping counters; updates dropped by a clear are still counted.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_updates_reg     <= '0;
            cnt_mispredicts_reg <= '0;
        end else begin
            if (bp.upd_valid) begin
                cnt_updates_reg <= cnt_updates_reg + CNT_W'(1);
            end
            if (misp) begin
                cnt_mispredicts_reg <= cnt_mispredicts_reg + CNT_W'(1);
            end
        end
    end

    assign bp.cnt_updates     = cnt_updates_reg;
    assign bp.cnt_mispredicts = cnt_mispredicts_reg;

endmodule
